clock_set_ctrl: RTL and testbench
=================================

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 SHALL have clk_1hz, input, 1 bit: clock, one tick per second; all state changes on its rising edge.
REQ-002 SHALL have rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have btn_mode, input, 1 bit: mode button level, already debounced, sampled on each clk_1hz edge.
REQ-004 SHALL have btn_inc, input, 1 bit: increment button level, already debounced, sampled on each clk_1hz edge.
REQ-005 SHALL have sec, output, 6 bits: seconds, range 0..59.
REQ-006 SHALL have min, output, 6 bits: minutes, range 0..59.
REQ-007 SHALL have hr, output, 5 bits: hours, range 0..23.
REQ-008 SHALL have mode, output, 3 bits: FSM state code, RUN=0, SET_HR=1, SET_MIN=2, AL_HR=3, AL_MIN=4.
REQ-009 SHALL have blink, output, 1 bit: display blink enable for the field being set.
REQ-010 SHALL have al_hr, output, 5 bits, and al_min, output, 6 bits: alarm time.
REQ-011 SHALL have alarm_hit, output, 1 bit: one-tick alarm pulse.

Function
REQ-012 SHALL register previous samples of both buttons; a press edge is defined as current=1 and previous=0.
REQ-013 SHALL advance mode on each btn_mode edge: RUN->SET_HR->SET_MIN->AL_HR->AL_MIN->RUN; with ALARM_EN undefined, SET_MIN->RUN.
REQ-014 SHALL, in RUN, advance time each tick: sec 59->0 carries to min, min 59->0 carries to hr, and 23:59:59 wraps to 00:00:00.
REQ-015 SHALL freeze sec, min and hr in SET_HR and SET_MIN; time SHALL keep running in AL_HR and AL_MIN.
REQ-016 SHALL clear sec to 0 on the tick that leaves SET_MIN, whether the exit is by mode edge or by timeout.
REQ-017 SHALL, on a btn_inc edge, increment exactly one field with no carry: SET_HR hr mod 24; SET_MIN min mod 60; AL_HR al_hr mod 24; AL_MIN al_min mod 60; btn_inc edges in RUN are ignored.
REQ-018 SHALL give btn_mode priority when both edges occur on the same tick: mode advances and the inc edge is discarded.
REQ-019 SHALL keep a 5-bit idle counter in non-RUN states; it SHALL clear on any press edge and increment otherwise.
REQ-020 SHALL force mode to RUN on the tick where the idle counter equals 29 and no edge is present, i.e. after 30 idle ticks, and SHALL clear the counter.
REQ-021 SHALL toggle blink every tick in non-RUN states; blink SHALL be 0 in RUN and on the tick of entry into RUN.
REQ-022 SHALL assert alarm_hit for exactly one tick, registered, when in RUN the time advances to al_hr:al_min:00; no pulse SHALL occur when the time is set to that value.

Reset
REQ-023 SHALL, on rst, asynchronously set sec=min=hr=0, mode=RUN, blink=0, al_hr=al_min=0, alarm_hit=0, idle counter=0, button history=0.
REQ-024 SHALL abandon any set operation when rst is asserted mid-operation; no partial increment SHALL survive.

Configuration
REQ-025 SHALL compile alarm logic only when CLOCK_SET_ALARM_EN is defined: AL_HR/AL_MIN states, al_hr/al_min registers and alarm_hit generation.
REQ-026 SHALL, without CLOCK_SET_ALARM_EN, keep all ports, tie al_hr, al_min and alarm_hit to 0, and never produce mode codes 3 or 4.

Verification
REQ-027 SHALL cover rollover: reset, run 86400 ticks in RUN -> time 00:00:00; and at 23:59:59 one tick -> 00:00:00.
REQ-028 SHALL cover setting: mode edge, then 3 inc edges -> hr=3 in SET_HR; mode edge, then 61 inc edges -> min=1 with hr unchanged; mode edge(s) to RUN -> sec=0.
REQ-029 SHALL cover timeout: enter SET_HR, no presses for 30 ticks -> mode=0 on the 30th tick, blink=0; with only 29 idle ticks mode stays 1.
REQ-030 SHALL cover a simultaneous edge: btn_mode and btn_inc rise on the same tick in SET_HR -> mode=2, hr unchanged.
REQ-031 SHALL cover the alarm, with CLOCK_SET_ALARM_EN defined: set al_hr=0 and al_min=2 from reset, run -> alarm_hit high for exactly one tick when time becomes 00:02:00; without the macro, alarm_hit stays 0.
REQ-032 SHALL cover reset mid-SET_MIN with btn_inc held: assert rst -> all outputs 0 immediately, mode=0, and no inc edge is detected after release while btn_inc stays high.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// Time-of-day clock with button-driven set mode and optional alarm.
// Alarm states, registers and pulse exist only when CLOCK_SET_ALARM_EN is defined.
module clock_set_ctrl (
    input  logic       clk_1hz,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hr,
    output logic [2:0] mode,
    output logic       blink,
    output logic [4:0] al_hr,
    output logic [5:0] al_min,
    output logic       alarm_hit
);

`ifdef CLOCK_SET_ALARM_EN
    typedef enum logic [2:0] {RUN = 3'd0, SET_HR = 3'd1, SET_MIN = 3'd2,
                              AL_HR = 3'd3, AL_MIN = 3'd4} state_t;
`else
    typedef enum logic [2:0] {RUN = 3'd0, SET_HR = 3'd1, SET_MIN = 3'd2} state_t;
`endif

    state_t     state, state_nxt;
    logic       mode_q, inc_q;
    logic       mode_edge, inc_edge, timeout, run_time;
    logic [4:0] idle;
    logic [5:0] sec_n, min_n;
    logic [4:0] hr_n;

    assign mode_edge = btn_mode & ~mode_q;
    assign inc_edge  = btn_inc & ~inc_q;
    assign timeout   = (state != RUN) && (idle == 5'd29) && !mode_edge && !inc_edge;
    assign mode      = state;

`ifdef CLOCK_SET_ALARM_EN
    assign run_time = (state == RUN) || (state == AL_HR) || (state == AL_MIN);
`else
    assign run_time = (state == RUN);
`endif

    always_comb begin
        state_nxt = state;
        if (mode_edge) begin
            case (state)
                RUN:     state_nxt = SET_HR;
                SET_HR:  state_nxt = SET_MIN;
`ifdef CLOCK_SET_ALARM_EN
                SET_MIN: state_nxt = AL_HR;
                AL_HR:   state_nxt = AL_MIN;
`endif
                default: state_nxt = RUN;
            endcase
        end else if (timeout) begin
            state_nxt = RUN;
        end
    end

    // Set-mode increments touch one field only; mode edge wins over inc edge.
    always_comb begin
        sec_n = sec;
        min_n = min;
        hr_n  = hr;
        if (run_time) begin
            if (sec == 6'd59) begin
                sec_n = 6'd0;
                if (min == 6'd59) begin
                    min_n = 6'd0;
                    hr_n  = (hr == 5'd23) ? 5'd0 : hr + 5'd1;
                end else begin
                    min_n = min + 6'd1;
                end
            end else begin
                sec_n = sec + 6'd1;
            end
        end else if (inc_edge && !mode_edge) begin
            if (state == SET_HR)
                hr_n = (hr == 5'd23) ? 5'd0 : hr + 5'd1;
            if (state == SET_MIN)
                min_n = (min == 6'd59) ? 6'd0 : min + 6'd1;
        end
        if (state == SET_MIN && state_nxt != SET_MIN)
            sec_n = 6'd0;
    end

    always_ff @(posedge clk_1hz or posedge rst) begin
        if (rst) begin
            state  <= RUN;
            sec    <= 6'd0;
            min    <= 6'd0;
            hr     <= 5'd0;
            blink  <= 1'b0;
            idle   <= 5'd0;
            mode_q <= 1'b0;
            inc_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            sec    <= sec_n;
            min    <= min_n;
            hr     <= hr_n;
            blink  <= (state_nxt == RUN) ? 1'b0 : ~blink;
            idle   <= (state == RUN || mode_edge || inc_edge || timeout) ? 5'd0 : idle + 5'd1;
            mode_q <= btn_mode;
            inc_q  <= btn_inc;
        end
    end

`ifdef CLOCK_SET_ALARM_EN
    // Pulse only on a running advance in RUN, so setting the time never fires it.
    always_ff @(posedge clk_1hz or posedge rst) begin
        if (rst) begin
            al_hr     <= 5'd0;
            al_min    <= 6'd0;
            alarm_hit <= 1'b0;
        end else begin
            if (inc_edge && !mode_edge && state == AL_HR)
                al_hr <= (al_hr == 5'd23) ? 5'd0 : al_hr + 5'd1;
            if (inc_edge && !mode_edge && state == AL_MIN)
                al_min <= (al_min == 6'd59) ? 6'd0 : al_min + 6'd1;
            alarm_hit <= (state == RUN) && (sec_n == 6'd0) &&
                         (min_n == al_min) && (hr_n == al_hr);
        end
    end
`else
    assign al_hr     = 5'd0;
    assign al_min    = 6'd0;
    assign alarm_hit = 1'b0;
`endif

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl; expectations follow CLOCK_SET_ALARM_EN.
module tb_clock_set_ctrl;

    logic       clk_1hz = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [5:0] sec, min, al_min;
    logic [4:0] hr, al_hr;
    logic [2:0] mode;
    logic       blink, alarm_hit;

    int n_chk = 0;
    int n_pass = 0;
    int hit_cnt = 0;
    int hit_stamp = 0;
    int max_mode = 0;

`ifdef CLOCK_SET_ALARM_EN
    localparam int ALARM = 1;
`else
    localparam int ALARM = 0;
`endif

    clock_set_ctrl dut (
        .clk_1hz  (clk_1hz),
        .rst      (rst),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .sec      (sec),
        .min      (min),
        .hr       (hr),
        .mode     (mode),
        .blink    (blink),
        .al_hr    (al_hr),
        .al_min   (al_min),
        .alarm_hit(alarm_hit)
    );

    always #5 clk_1hz = ~clk_1hz;

    function automatic int hms(input int h, input int m, input int s);
        return (h << 12) | (m << 6) | s;
    endfunction

    function automatic int now();
        return hms(int'(hr), int'(min), int'(sec));
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_1hz);
        #1;
        if (alarm_hit) begin
            hit_cnt++;
            hit_stamp = now();
        end
        if (int'(mode) > max_mode) max_mode = int'(mode);
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        tick();
        btn_mode = 1'b0;
        tick();
    endtask

    task automatic press_inc();
        btn_inc = 1'b1;
        tick();
        btn_inc = 1'b0;
        tick();
    endtask

    initial begin
        // reset state
        tick();
        tick();
        check("rst_time", now(), 0);
        check("rst_mode", int'(mode), 0);
        check("rst_blink", int'(blink), 0);
        check("rst_alarm", int'({al_hr, al_min, alarm_hit}), 0);
        rst = 1'b0;

        // rollover
        tick();
        check("run_1s", now(), hms(0, 0, 1));
        for (int i = 1; i < 60; i++) tick();
        check("run_60s", now(), hms(0, 1, 0));
        for (int i = 60; i < 3600; i++) tick();
        check("run_1h", now(), hms(1, 0, 0));
        for (int i = 3600; i < 86399; i++) tick();
        check("run_235959", now(), hms(23, 59, 59));
        tick();
        check("run_wrap", now(), 0);

        // setting
        for (int i = 0; i < 5; i++) tick();
        btn_mode = 1'b1;
        tick();
        btn_mode = 1'b0;
        check("enter_sethr", int'(mode), 1);
        check("blink_on", int'(blink), 1);
        tick();
        check("blink_toggle", int'(blink), 0);
        for (int i = 0; i < 3; i++) press_inc();
        check("set_hr3", now(), hms(3, 0, 6));
        press_mode();
        check("enter_setmin", int'(mode), 2);
        for (int i = 0; i < 61; i++) press_inc();
        check("set_min61", now(), hms(3, 1, 6));
        btn_mode = 1'b1;
        tick();
        btn_mode = 1'b0;
        check("exit_setmin_sec", int'(sec), 0);
        check("exit_setmin_mode", int'(mode), ALARM ? 3 : 0);
        tick();
`ifdef CLOCK_SET_ALARM_EN
        press_mode();
        press_mode();
        check("back_to_run", int'(mode), 0);
`else
        check("run_blink", int'(blink), 0);
        btn_inc = 1'b1;
        tick();
        btn_inc = 1'b0;
        check("run_ignores_inc", now(), hms(3, 1, 2));
`endif

        // idle timeout
        btn_mode = 1'b1;
        tick();
        btn_mode = 1'b0;
        for (int i = 0; i < 29; i++) tick();
        check("idle29_mode", int'(mode), 1);
        tick();
        check("idle30_mode", int'(mode), 0);
        check("idle30_blink", int'(blink), 0);

        // simultaneous edges in SET_HR
        press_mode();
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        tick();
        check("simul_mode", int'(mode), 2);
        check("simul_hr", int'(hr), 3);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        tick();

        // reset mid-SET_MIN with btn_inc held
        btn_inc = 1'b1;
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("midrst_time", now(), 0);
        check("midrst_mode", int'(mode), 0);
        check("midrst_other", int'({blink, al_hr, al_min, alarm_hit}), 0);
        rst = 1'b0;
        tick();
        check("postrst_run", now(), hms(0, 0, 1));
        press_mode();
        tick();
        tick();
        check("held_inc_no_edge", int'(hr), 0);
        check("held_inc_mode", int'(mode), 1);
        btn_inc = 1'b0;

        // alarm
        #2;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        hit_cnt  = 0;
        max_mode = 0;
        for (int i = 0; i < 4; i++) press_mode();
        press_inc();
        press_inc();
        btn_mode = 1'b1;
        tick();
        btn_mode = 1'b0;
        for (int i = 0; i < 200; i++) tick();
        check("alarm_hits", hit_cnt, ALARM ? 1 : 0);
        check("alarm_regs", int'({al_hr, al_min}), ALARM ? 2 : 0);
        check("max_mode", max_mode, ALARM ? 4 : 2);
`ifdef CLOCK_SET_ALARM_EN
        check("alarm_stamp", hit_stamp, hms(0, 2, 0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
